// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and types shared by the PS/2 key tracker files.
//   PS2_BRK_CODE : scancode prefix announcing a key release (break)
//   PS2_EXT_CODE : scancode prefix announcing an extended key
//   pop_state_t  : states of the receiver-FIFO pop sequencer
package ps2_pkg;

  localparam logic [7:0] PS2_BRK_CODE = 8'hF0;
  localparam logic [7:0] PS2_EXT_CODE = 8'hE0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    DONE = 2'd2
  } pop_state_t;

endpackage

// File: rtl/bcd_counter.sv
// bcd_counter: multi-digit decimal counter, one BCD nibble per digit.
// Wraps from all-9s to all-0s.
//   clk    in   system clock
//   reset  in   synchronous active-high reset, clears the count
//   inc    in   add one on this clock edge
//   value  out  count, digit 0 in bits [3:0]
module bcd_counter #(
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc,
  output logic [4*DIGITS-1:0]   value
);

  logic [4*DIGITS-1:0] value_nxt;

  // Ripple the carry digit by digit; a digit at 9 rolls to 0 and passes
  // the carry on, any other digit absorbs it.
  always_comb begin
    logic carry;
    value_nxt = value;
    carry     = inc;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (value[4*i +: 4] >= 4'd9) begin
          value_nxt[4*i +: 4] = 4'd0;
        end else begin
          value_nxt[4*i +: 4] = value[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
    end else begin
      value <= value_nxt;
    end
  end

endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: pops scancode bytes from a PS/2 receiver FIFO, tracks the
// currently held key, counts new key presses in BCD and builds a hex display.
// Optional feature: define PS2_EXT_PREFIX_EN to honour the 0xE0 extended
// prefix; without it 0xE0 bytes are dropped and key_ext is constant 0.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   kbd_data          head byte of the receiver FIFO
//   kbd_ready         FIFO non-empty
//   kbd_overflow      FIFO overflowed
//   kbd_nextdata_n    active-low pop strobe (low for one cycle per byte)
//   kbd_clrn          active-low receiver clear (low in reset / after overflow)
//   key_code, key_ext scancode and extended flag of the held key
//   key_held          a key is currently held
//   key_event         one-cycle pulse per counted press
//   press_cnt         BCD press count, digit 0 in bits [3:0]
//   ovf_err           sticky overflow flag
//   disp_data         one hex nibble per display digit
//   disp_select       per-digit enable, 1 = lit
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int CNT_DIGITS = 3,
  parameter int NUM_DIGITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              kbd_data,
  input  logic                    kbd_ready,
  input  logic                    kbd_overflow,
  output logic                    kbd_nextdata_n,
  output logic                    kbd_clrn,
  output logic [7:0]              key_code,
  output logic                    key_ext,
  output logic                    key_held,
  output logic                    key_event,
  output logic [4*CNT_DIGITS-1:0] press_cnt,
  output logic                    ovf_err,
  output logic [4*NUM_DIGITS-1:0] disp_data,
  output logic [NUM_DIGITS-1:0]   disp_select
);

  if (CNT_DIGITS < 1 || CNT_DIGITS > 6) begin : g_bad_cnt_digits
    $error("ps2_key_tracker: CNT_DIGITS must be in 1..6");
  end
  if (NUM_DIGITS < CNT_DIGITS + 2) begin : g_bad_num_digits
    $error("ps2_key_tracker: NUM_DIGITS must be at least CNT_DIGITS+2");
  end

  pop_state_t state, state_nxt;
  logic [7:0] byte_q;
  logic       brk_flag;
`ifdef PS2_EXT_PREFIX_EN
  logic       ext_flag;
`endif

  logic dec_en, is_brk, is_ext, non_prefix, same_key, make_new, brk_hit;
  logic [4*NUM_DIGITS-1:0] disp_nxt;
  logic [NUM_DIGITS-1:0]   sel_nxt;

  // Next-state logic. While kbd_clrn is low the receiver is being cleared
  // and its ready flag is stale, so no new byte is accepted in that cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (kbd_ready && kbd_clrn) state_nxt = POP;
      POP:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (kbd_overflow) state_nxt = IDLE;
  end

  // Decode of the latched byte, evaluated during the POP cycle.
  always_comb begin
    dec_en     = (state == POP) && !kbd_overflow;
    is_brk     = (byte_q == PS2_BRK_CODE);
    is_ext     = (byte_q == PS2_EXT_CODE);
    non_prefix = !is_brk && !is_ext;
`ifdef PS2_EXT_PREFIX_EN
    same_key   = key_held && (byte_q == key_code) && (ext_flag == key_ext);
`else
    same_key   = key_held && (byte_q == key_code);
`endif
    // A make of the held key is typematic repeat and is not counted.
    make_new   = dec_en && non_prefix && !brk_flag && !same_key;
    brk_hit    = dec_en && non_prefix &&  brk_flag &&  same_key;
  end

  always_comb begin
    disp_nxt                      = '0;
    disp_nxt[7:0]                 = key_code;
    disp_nxt[8 +: 4*CNT_DIGITS]   = press_cnt;
    sel_nxt                       = '0;
    sel_nxt[1:0]                  = {2{key_held}};
    sel_nxt[2 +: CNT_DIGITS]      = '1;
  end

  // Byte capture: data register, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && state_nxt == POP) begin
      byte_q <= kbd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      kbd_nextdata_n <= 1'b1;
      kbd_clrn       <= 1'b0;
      brk_flag       <= 1'b0;
`ifdef PS2_EXT_PREFIX_EN
      ext_flag       <= 1'b0;
      key_ext        <= 1'b0;
`endif
      key_code       <= '0;
      key_held       <= 1'b0;
      key_event      <= 1'b0;
      ovf_err        <= 1'b0;
      disp_data      <= '0;
      disp_select    <= '0;
    end else begin
      state          <= state_nxt;
      kbd_nextdata_n <= (state_nxt != POP);
      // One low cycle per overflow report, even if the flag lingers.
      kbd_clrn       <= !(kbd_overflow && kbd_clrn);
      key_event      <= make_new;
      disp_data      <= disp_nxt;
      disp_select    <= sel_nxt;
      if (kbd_overflow) begin
        ovf_err  <= 1'b1;
        brk_flag <= 1'b0;
`ifdef PS2_EXT_PREFIX_EN
        ext_flag <= 1'b0;
`endif
        key_held <= 1'b0;
      end else if (dec_en) begin
        if (is_brk) begin
          brk_flag <= 1'b1;
        end else if (is_ext) begin
`ifdef PS2_EXT_PREFIX_EN
          ext_flag <= 1'b1;
`endif
        end else begin
          brk_flag <= 1'b0;
`ifdef PS2_EXT_PREFIX_EN
          ext_flag <= 1'b0;
`endif
          if (make_new) begin
            key_code <= byte_q;
`ifdef PS2_EXT_PREFIX_EN
            key_ext  <= ext_flag;
`endif
            key_held <= 1'b1;
          end else if (brk_hit) begin
            key_held <= 1'b0;
          end
        end
      end
    end
  end

`ifndef PS2_EXT_PREFIX_EN
  assign key_ext = 1'b0;
`endif

  bcd_counter #(
    .DIGITS (CNT_DIGITS)
  ) u_press_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (make_new),
    .value (press_cnt)
  );

endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: self-checking bench for ps2_key_tracker with a
// behavioural receiver FIFO and an integer-level key/press reference model.
module tb_ps2_key_tracker;

  localparam int CNT = 3;
  localparam int NUM = 8;
  localparam int MOD = 1000;
`ifdef PS2_EXT_PREFIX_EN
  localparam bit EXT = 1'b1;
`else
  localparam bit EXT = 1'b0;
`endif

  logic             clk;
  logic             reset;
  logic [7:0]       kbd_data;
  logic             kbd_ready;
  logic             kbd_overflow;
  logic             kbd_nextdata_n;
  logic             kbd_clrn;
  logic [7:0]       key_code;
  logic             key_ext;
  logic             key_held;
  logic             key_event;
  logic [4*CNT-1:0] press_cnt;
  logic             ovf_err;
  logic [4*NUM-1:0] disp_data;
  logic [NUM-1:0]   disp_select;

  ps2_key_tracker #(.CNT_DIGITS(CNT), .NUM_DIGITS(NUM)) dut (
    .clk            (clk),
    .reset          (reset),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .kbd_clrn       (kbd_clrn),
    .key_code       (key_code),
    .key_ext        (key_ext),
    .key_held       (key_held),
    .key_event      (key_event),
    .press_cnt      (press_cnt),
    .ovf_err        (ovf_err),
    .disp_data      (disp_data),
    .disp_select    (disp_select)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Receiver FIFO model: pops on a low strobe, empties on a low clear.
  logic [7:0] fifo[$];
  int         pop_count = 0;
  int         cyc = 0;
  int         pop_cyc[$];

  initial begin
    bit pop_now, clr_now;
    kbd_ready = 1'b0;
    kbd_data  = 8'h00;
    forever begin
      @(posedge clk);
      pop_now = (kbd_nextdata_n === 1'b0);
      clr_now = (kbd_clrn === 1'b0);
      cyc++;
      #1;
      if (clr_now) begin
        fifo.delete();
      end else if (pop_now && fifo.size() > 0) begin
        void'(fifo.pop_front());
        pop_count++;
        pop_cyc.push_back(cyc);
      end
      kbd_ready = (fifo.size() != 0);
      kbd_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
    end
  end

  int ev_count = 0;
  initial begin
    forever begin
      @(posedge clk);
      if (key_event === 1'b1) ev_count++;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: key state and press count as plain integers.
  bit         m_brk, m_ext, m_held, m_kext;
  logic [7:0] m_code;
  int         m_cnt, m_events;

  function automatic void model_reset();
    m_brk = 0; m_ext = 0; m_held = 0; m_kext = 0;
    m_code = 8'h00; m_cnt = 0; m_events = 0;
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    bit e;
    if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
      if (EXT) m_ext = 1;
    end else begin
      e = EXT ? m_ext : 1'b0;
      if (!m_brk) begin
        if (!(m_held && b == m_code && e == m_kext)) begin
          m_code = b; m_kext = e; m_held = 1;
          m_cnt = (m_cnt + 1) % MOD;
          m_events++;
        end
      end else if (m_held && b == m_code && e == m_kext) begin
        m_held = 0;
      end
      m_brk = 0; m_ext = 0;
    end
  endfunction

  function automatic logic [4*CNT-1:0] to_bcd(input int v);
    logic [4*CNT-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < CNT; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (fifo.size() != 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (fifo.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d bytes left expected 0", fifo.size());
      fifo.delete();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    model_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic chk_disp(input string tag, input logic [7:0] code, input bit held, input int cnt);
    logic [4*NUM-1:0] ed;
    logic [NUM-1:0]   es;
    ed = '0;
    ed[7:0] = code;
    ed[8 +: 4*CNT] = to_bcd(cnt);
    es = '0;
    es[1:0] = {held, held};
    es[2 +: CNT] = '1;
    chk({tag, "_disp_data"}, 64'(disp_data), 64'(ed));
    chk({tag, "_disp_select"}, 64'(disp_select), 64'(es));
  endtask

  task automatic chk_model(input string tag, input int ev_base);
    chk({tag, "_code"}, 64'(key_code), 64'(m_code));
    chk({tag, "_ext"},  64'(key_ext),  64'(m_kext));
    chk({tag, "_held"}, 64'(key_held), 64'(m_held));
    chk({tag, "_cnt"},  64'(press_cnt), 64'(to_bcd(m_cnt)));
    chk({tag, "_events"}, 64'(ev_count - ev_base), 64'(m_events));
  endtask

  typedef struct {
    logic [7:0] b;
    logic [7:0] code;
    logic       ext;
    logic       held;
    int         cnt;
  } vec_t;

  vec_t       tbl[18];
  logic [7:0] pool[6];

  initial begin
    int ev_base, pc_base, ok;
    logic [7:0] b;

    tbl[0]  = '{8'h1C, 8'h1C, 1'b0, 1'b1, 1};
    tbl[1]  = '{8'h1C, 8'h1C, 1'b0, 1'b1, 1};
    tbl[2]  = '{8'h1C, 8'h1C, 1'b0, 1'b1, 1};
    tbl[3]  = '{8'hF0, 8'h1C, 1'b0, 1'b1, 1};
    tbl[4]  = '{8'h1C, 8'h1C, 1'b0, 1'b0, 1};
    tbl[5]  = '{8'hE0, 8'h1C, 1'b0, 1'b0, 1};
    tbl[6]  = '{8'h75, 8'h75, EXT,  1'b1, 2};
    tbl[7]  = '{8'hE0, 8'h75, EXT,  1'b1, 2};
    tbl[8]  = '{8'hF0, 8'h75, EXT,  1'b1, 2};
    tbl[9]  = '{8'h75, 8'h75, EXT,  1'b0, 2};
    tbl[10] = '{8'hF0, 8'h75, EXT,  1'b0, 2};
    tbl[11] = '{8'h33, 8'h75, EXT,  1'b0, 2};
    tbl[12] = '{8'h33, 8'h33, 1'b0, 1'b1, 3};
    tbl[13] = '{8'h75, 8'h75, 1'b0, 1'b1, 4};
    tbl[14] = '{8'hF0, 8'h75, 1'b0, 1'b1, 4};
    tbl[15] = '{8'h33, 8'h75, 1'b0, 1'b1, 4};
    tbl[16] = '{8'hE0, 8'h75, 1'b0, 1'b1, 4};
    tbl[17] = '{8'h75, 8'h75, EXT,  1'b1, 4 + int'(EXT)};
    pool = '{8'h1C, 8'h1B, 8'h33, 8'h75, 8'hE0, 8'hF0};

    reset = 1'b1;
    kbd_overflow = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_nextdata_n", 64'(kbd_nextdata_n), 64'd1);
    chk("rst_clrn",       64'(kbd_clrn),       64'd0);
    chk("rst_code",       64'(key_code),       64'd0);
    chk("rst_ext",        64'(key_ext),        64'd0);
    chk("rst_held",       64'(key_held),       64'd0);
    chk("rst_event",      64'(key_event),      64'd0);
    chk("rst_cnt",        64'(press_cnt),      64'd0);
    chk("rst_ovf",        64'(ovf_err),        64'd0);
    chk("rst_disp_data",  64'(disp_data),      64'd0);
    chk("rst_disp_sel",   64'(disp_select),    64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("post_rst_clrn",  64'(kbd_clrn),       64'd1);

    // Single make after reset
    ev_base = ev_count; pc_base = pop_count;
    push(8'h1C);
    wait_drain(50);
    chk("first_pops",   64'(pop_count - pc_base), 64'd1);
    chk("first_code",   64'(key_code),  64'h1C);
    chk("first_held",   64'(key_held),  64'd1);
    chk("first_cnt",    64'(press_cnt), 64'h001);
    chk("first_events", 64'(ev_count - ev_base), 64'd1);
    chk("first_sel",    64'(disp_select), 64'b0001_1111);

    // Table-driven byte-by-byte sequence from reset
    do_reset();
    ev_base = ev_count;
    for (int i = 0; i < 18; i++) begin
      push(tbl[i].b);
      wait_drain(50);
      chk($sformatf("tbl%0d_code", i),   64'(key_code),  64'(tbl[i].code));
      chk($sformatf("tbl%0d_ext", i),    64'(key_ext),   64'(tbl[i].ext));
      chk($sformatf("tbl%0d_held", i),   64'(key_held),  64'(tbl[i].held));
      chk($sformatf("tbl%0d_cnt", i),    64'(press_cnt), 64'(to_bcd(tbl[i].cnt)));
      chk($sformatf("tbl%0d_events", i), 64'(ev_count - ev_base), 64'(tbl[i].cnt));
      chk_disp($sformatf("tbl%0d", i), tbl[i].code, tbl[i].held, tbl[i].cnt);
    end

    // Back-to-back bytes: repeats, then release, three-cycle pop spacing
    do_reset();
    pop_cyc.delete();
    pc_base = pop_count;
    push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    wait_drain(100);
    chk("burst_pops", 64'(pop_count - pc_base), 64'd5);
    chk("burst_cnt",  64'(press_cnt), 64'h001);
    chk("burst_held", 64'(key_held),  64'd0);
    for (int i = 1; i < pop_cyc.size(); i++) begin
      chk($sformatf("burst_spacing%0d", i), 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd3);
    end

    // Randomized bursts against the reference model
    do_reset();
    ev_base = ev_count;
    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        b = pool[$urandom_range(0, 5)];
        push(b);
        model_byte(b);
      end
      wait_drain(100);
      chk_model($sformatf("rnd%0d", r), ev_base);
    end

    // Overflow together with ready: no pop, one-cycle clear, sticky error
    do_reset();
    push(8'h1C);
    wait_drain(50);
    pc_base = pop_count; ev_base = ev_count;
    push(8'h29);
    @(posedge clk); #2;
    kbd_overflow = 1'b1;
    chk("ovf_ready_seen", 64'(kbd_ready), 64'd1);
    @(posedge clk); #2;
    kbd_overflow = 1'b0;
    chk("ovf_clrn_low",   64'(kbd_clrn),       64'd0);
    chk("ovf_nextdata_n", 64'(kbd_nextdata_n), 64'd1);
    chk("ovf_err_set",    64'(ovf_err),        64'd1);
    chk("ovf_held",       64'(key_held),       64'd0);
    chk("ovf_cnt",        64'(press_cnt),      64'h001);
    @(posedge clk); #2;
    chk("ovf_clrn_back",  64'(kbd_clrn),       64'd1);
    repeat (6) @(posedge clk);
    #2;
    chk("ovf_no_pop",     64'(pop_count - pc_base), 64'd0);
    chk("ovf_no_event",   64'(ev_count - ev_base),  64'd0);
    chk("ovf_code_kept",  64'(key_code),       64'h1C);
    push(8'h33);
    wait_drain(50);
    chk("ovf_sticky",     64'(ovf_err),        64'd1);
    chk("ovf_after_cnt",  64'(press_cnt),      64'h002);

    // Reset while the pop strobe is low
    push(8'h44);
    ok = 0;
    for (int n = 0; n < 20 && ok == 0; n++) begin
      @(posedge clk); #2;
      if (kbd_nextdata_n === 1'b0) ok = 1;
    end
    chk("midpop_found", 64'(ok), 64'd1);
    reset = 1'b1;
    @(posedge clk); #2;
    chk("midpop_nextdata_n", 64'(kbd_nextdata_n), 64'd1);
    chk("midpop_code",       64'(key_code),       64'd0);
    chk("midpop_held",       64'(key_held),       64'd0);
    chk("midpop_event",      64'(key_event),      64'd0);
    chk("midpop_cnt",        64'(press_cnt),      64'd0);
    chk("midpop_ovf",        64'(ovf_err),        64'd0);
    chk("midpop_clrn",       64'(kbd_clrn),       64'd0);
    chk("midpop_disp",       64'(disp_data),      64'd0);
    chk("midpop_sel",        64'(disp_select),    64'd0);
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;

    // 999 presses, then one more wraps the counter
    do_reset();
    ev_base = ev_count;
    for (int i = 0; i < 999; i++) push((i % 2 == 0) ? 8'h1C : 8'h1B);
    wait_drain(3500);
    chk("wrap_pre_cnt",    64'(press_cnt), 64'h999);
    chk("wrap_pre_events", 64'(ev_count - ev_base), 64'd999);
    ev_base = ev_count;
    push(8'h1B);
    wait_drain(50);
    chk("wrap_cnt",    64'(press_cnt), 64'h000);
    chk("wrap_event",  64'(ev_count - ev_base), 64'd1);
    chk("wrap_code",   64'(key_code),  64'h1B);
    chk_disp("wrap", 8'h1B, 1'b1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
